// File: rtl/lfsr_meas_sequencer.sv
// Measurement-run sequencer for the modem PRBS test path: symbol enable, PRBS reset hold,
// warm-up/measure windows, accumulator strobes and rollover counting.
module lfsr_meas_sequencer #(
    parameter int unsigned SYM_DIV     = 4,
    parameter int unsigned WARMUP_SYMS = 32,
    parameter int unsigned MEAS_SYMS   = 2048,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             rollover_in,
    output logic             sym_clk_ena,
    output logic             lfsr_reset,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             dump,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sym_count,
    output logic [7:0]       rollover_count
);

    localparam int unsigned DIV_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SYM_DIV - 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_SYMS - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_SYMS - 1);
    localparam logic [CNT_W-1:0] MEAS_FULL = CNT_W'(MEAS_SYMS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEED    = 3'd1;
    localparam logic [2:0] S_WARMUP  = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_DUMP    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] sym_q, sym_d;
    logic [7:0]       roll_q, roll_d;
    logic             sym_clk_ena_q, sym_clk_ena_d;
    logic             lfsr_reset_q, lfsr_reset_d;
    logic             acc_clr_q, acc_clr_d;
    logic             acc_en_q, acc_en_d;
    logic             dump_q, dump_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Free-running symbol divider; only reset clears it.
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        sym_clk_ena_d = (div_q == DIV_LAST);
    end

    // Next-state, counters and registered output decode.
    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        roll_d  = roll_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_SEED;
                        sym_d   = '0;
                        roll_d  = '0;
                    end
                end
                S_SEED: state_d = S_WARMUP;
                S_WARMUP: begin
                    if (sym_clk_ena_q) begin
                        if (sym_q == WARM_LAST) begin
                            sym_d   = '0;
                            state_d = S_MEASURE;
                        end else begin
                            sym_d = sym_q + CNT_W'(1);
                        end
                    end
                end
                S_MEASURE: begin
                    if (rollover_in && (roll_q != 8'hFF)) begin
                        roll_d = roll_q + 8'd1;
                    end
                    if (sym_clk_ena_q) begin
                        if (sym_q == MEAS_LAST) begin
                            sym_d   = MEAS_FULL;
                            state_d = S_DUMP;
                        end else begin
                            sym_d = sym_q + CNT_W'(1);
                        end
                    end
                end
                S_DUMP: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end

        lfsr_reset_d = (state_d == S_IDLE) || (state_d == S_SEED) || (state_d == S_DONE);
        busy_d       = (state_d == S_SEED) || (state_d == S_WARMUP) ||
                       (state_d == S_MEASURE) || (state_d == S_DUMP);
        done_d       = (state_d == S_DONE);
        acc_en_d     = (state_d == S_MEASURE);
        dump_d       = (state_d == S_DUMP);
        acc_clr_d    = (state_q == S_SEED) && (state_d == S_WARMUP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            sym_q         <= '0;
            roll_q        <= '0;
            sym_clk_ena_q <= 1'b0;
            lfsr_reset_q  <= 1'b1;
            acc_clr_q     <= 1'b0;
            acc_en_q      <= 1'b0;
            dump_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            sym_q         <= sym_d;
            roll_q        <= roll_d;
            sym_clk_ena_q <= sym_clk_ena_d;
            lfsr_reset_q  <= lfsr_reset_d;
            acc_clr_q     <= acc_clr_d;
            acc_en_q      <= acc_en_d;
            dump_q        <= dump_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign sym_clk_ena    = sym_clk_ena_q;
    assign lfsr_reset     = lfsr_reset_q;
    assign acc_clr        = acc_clr_q;
    assign acc_en         = acc_en_q;
    assign dump           = dump_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign sym_count      = sym_q;
    assign rollover_count = roll_q;

endmodule
